voice_mixer: RTL and testbench

- Consumer end of the per-voice pipeline output interface.
- Each pipeline drives a 2-bit state (IDLE/BSY/RDY) and a signed 16-bit sample. On every sample tick, this block snapshots all voices and scans them sequentially, one voice per cycle.
- It sums only the voices reporting RDY, applies gain shift and saturation, and emits one mixed sample with a valid pulse toward the DAC/codec path.

---
 rtl/synth_pkg.sv | 17 +
 rtl/sat_shift.sv | 31 +++
 rtl/voice_mixer.sv | 137 +++++++++++++
 tb/tb_voice_mixer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the voice pipelines and the mixer: voice state codes,
// sample width and the mixer FSM encoding.
package synth_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BSY  = 2'b01;
    localparam logic [1:0] ST_RDY  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_OUT  = 2'b10
    } mix_state_t;

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift (floors toward -inf) then saturation to a signed sample.
// Purely combinational, no backpressure.
module sat_shift
    import synth_pkg::*;
#(
    parameter int ACC_W = 19,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0]    acc_i,
    output logic signed [SAMPLE_W-1:0] sat_o
);

    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_i >>> SHIFT;

    always_comb begin
        sat_o = shifted[SAMPLE_W-1:0];
        if (shifted > MAX_V) begin
            sat_o = MAX_V[SAMPLE_W-1:0];
        end else if (shifted < MIN_V) begin
            sat_o = MIN_V[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Snapshots all voices on a tick, sums the RDY ones one per cycle, emits a saturated mix.
// Latency NUM_VOICES+2 edges; no backpressure: ticks arriving while busy are dropped and flag o_overrun.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int  NUM_VOICES = 8,
    parameter int  SHIFT      = 0,
    localparam int ACC_W      = SAMPLE_W + $clog2(NUM_VOICES),
    localparam int CNT_W      = $clog2(NUM_VOICES + 1),
    localparam int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    input  logic [2*NUM_VOICES-1:0]          i_states,
    input  logic [SAMPLE_W*NUM_VOICES-1:0]   i_signals,
    input  logic                             i_clr_ovr,
    output logic signed [SAMPLE_W-1:0]       o_sample,
    output logic                             o_valid,
    output logic [CNT_W-1:0]                 o_active,
    output logic                             o_busy,
    output logic                             o_overrun
);

    mix_state_t                              state_q, state_d;
    logic [NUM_VOICES-1:0][1:0]              snap_st_q, snap_st_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]     snap_sig_q, snap_sig_d;
    logic signed [ACC_W-1:0]                 acc_q, acc_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic signed [SAMPLE_W-1:0]              sample_q, sample_d;
    logic                                    valid_q, valid_d;
    logic [CNT_W-1:0]                        active_q, active_d;
    logic                                    overrun_q, overrun_d;

    logic [1:0]                              cur_st;
    logic [SAMPLE_W-1:0]                     cur_sig;
    logic signed [SAMPLE_W-1:0]              sat_sample;

    assign cur_st  = snap_st_q[idx_q];
    assign cur_sig = snap_sig_q[idx_q];

    sat_shift #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc_i (acc_q),
        .sat_o (sat_sample)
    );

    always_comb begin
        state_d    = state_q;
        snap_st_d  = snap_st_q;
        snap_sig_d = snap_sig_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        active_d   = active_q;
        overrun_d  = overrun_q;

        if (i_clr_ovr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (clk_en) begin
                    snap_st_d  = i_states;
                    snap_sig_d = i_signals;
                    acc_d      = '0;
                    cnt_d      = '0;
                    idx_d      = '0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur_st == ST_RDY) begin
                    acc_d = acc_q + {{(ACC_W-SAMPLE_W){cur_sig[SAMPLE_W-1]}}, cur_sig};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                sample_d = sat_sample;
                active_d = cnt_q;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A tick during scan or on the output edge is dropped; set beats clear.
        if (clk_en && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            snap_st_q  <= '0;
            snap_sig_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            active_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_st_q  <= snap_st_d;
            snap_sig_q <= snap_sig_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_sample  = sample_q;
    assign o_valid   = valid_q;
    assign o_active  = active_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: two 4-voice instances (SHIFT=0 and SHIFT=2) share stimulus.
module tb_voice_mixer;

    logic                clk = 1'b0;
    logic                rst;
    logic                clk_en;
    logic                i_clr_ovr;
    logic [7:0]          i_states;
    logic [63:0]         i_signals;

    logic signed [15:0]  o_sample0, o_sample2;
    logic                o_valid0, o_valid2;
    logic [2:0]          o_active0, o_active2;
    logic                o_busy0, o_busy2;
    logic                o_overrun0, o_overrun2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(4), .SHIFT(0)) u_d0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_states(i_states),
        .i_signals(i_signals), .i_clr_ovr(i_clr_ovr), .o_sample(o_sample0),
        .o_valid(o_valid0), .o_active(o_active0), .o_busy(o_busy0),
        .o_overrun(o_overrun0)
    );

    voice_mixer #(.NUM_VOICES(4), .SHIFT(2)) u_d2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_states(i_states),
        .i_signals(i_signals), .i_clr_ovr(i_clr_ovr), .o_sample(o_sample2),
        .o_valid(o_valid2), .o_active(o_active2), .o_busy(o_busy2),
        .o_overrun(o_overrun2)
    );

    // Reference: sum of RDY voices, floor-divided by 2^sh, clipped to 16 bits.
    function automatic int model_mix(input logic [7:0] st, input logic [63:0] sg,
                                     input int sh, output int act);
        int sum;
        logic signed [15:0] v;
        sum = 0;
        act = 0;
        for (int k = 0; k < 4; k++) begin
            if (st[2*k +: 2] == 2'b10) begin
                v = sg[16*k +: 16];
                sum = sum + v;
                act = act + 1;
            end
        end
        sum = sum >>> sh;
        if (sum > 32767) return 32767;
        if (sum < -32768) return -32768;
        return sum;
    endfunction

    // Apply inputs, tick once, and wait (bounded) for the valid pulse.
    task automatic do_mix(input logic [7:0] st, input logic [63:0] sg, output int lat);
        i_states  = st;
        i_signals = sg;
        @(posedge clk); #1;
        clk_en = 1'b1;
        @(posedge clk); #1;
        clk_en = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1 || lat < 0) begin
                @(posedge clk); #1;
            end
            if (o_valid0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int nv;
        rst = 1'b1; clk_en = 1'b0; i_clr_ovr = 1'b0; i_states = '0; i_signals = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_sample0 !== 16'sd0 || o_sample2 !== 16'sd0) begin errors++; $display("FAIL reset_sample got %0d/%0d want 0", o_sample0, o_sample2); end
        checks++; if (o_valid0 !== 1'b0 || o_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", o_valid0, o_valid2); end
        checks++; if (o_active0 !== 3'd0 || o_busy0 !== 1'b0 || o_overrun0 !== 1'b0) begin errors++; $display("FAIL reset_misc active=%0d busy=%b ovr=%b want 0", o_active0, o_busy0, o_overrun0); end
        rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_valid0 || o_valid2 || o_busy0) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL idle_quiet got %0d active cycles want 0", nv); end
    endtask

    task automatic test_basic;
        logic [63:0] sg;
        int lat;
        sg[15:0] = 16'sd1000; sg[31:16] = -16'sd250; sg[47:32] = 16'sd5000; sg[63:48] = 16'sd7;
        do_mix(8'b00_01_10_10, sg, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (o_sample0 !== 16'sd750) begin errors++; $display("FAIL basic_sample got %0d want 750", o_sample0); end
        checks++; if (o_active0 !== 3'd2) begin errors++; $display("FAIL basic_active got %0d want 2", o_active0); end
        checks++; if (o_sample2 !== 16'sd187 || o_valid2 !== 1'b1) begin errors++; $display("FAIL basic_shift2 got %0d v=%b want 187 v=1", o_sample2, o_valid2); end
        @(posedge clk); #1;
        checks++; if (o_valid0 !== 1'b0 || o_sample0 !== 16'sd750) begin errors++; $display("FAIL basic_pulse got v=%b s=%0d want v=0 s=750", o_valid0, o_sample0); end
    endtask

    task automatic test_saturation;
        int lat;
        do_mix(8'b10101010, {4{16'sd20000}}, lat);
        checks++; if (lat !== 5 || o_sample0 !== 16'sd32767 || o_active0 !== 3'd4) begin errors++; $display("FAIL sat_pos got lat=%0d s=%0d a=%0d want 5 32767 4", lat, o_sample0, o_active0); end
        checks++; if (o_sample2 !== 16'sd20000) begin errors++; $display("FAIL sat_pos_shift2 got %0d want 20000", o_sample2); end
        do_mix(8'b10101010, {4{-16'sd20000}}, lat);
        checks++; if (lat !== 5 || o_sample0 !== -16'sd32768) begin errors++; $display("FAIL sat_neg got lat=%0d s=%0d want 5 -32768", lat, o_sample0); end
        checks++; if (o_sample2 !== -16'sd20000) begin errors++; $display("FAIL sat_neg_shift2 got %0d want -20000", o_sample2); end
    endtask

    task automatic test_snapshot;
        int lat;
        logic [63:0] sg;
        sg = 64'h1234_5678_0064_7FFF;
        i_states = 8'b00_01_10_11; i_signals = sg;
        @(posedge clk); #1; clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        i_states = 8'hAA; i_signals[31:16] = 16'sd9999;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (o_valid0) begin lat = c; break; end
        end
        checks++; if (lat !== 5 || o_sample0 !== 16'sd100 || o_active0 !== 3'd1) begin errors++; $display("FAIL snapshot got lat=%0d s=%0d a=%0d want 5 100 1", lat, o_sample0, o_active0); end
        checks++; if (o_sample2 !== 16'sd25) begin errors++; $display("FAIL snapshot_shift2 got %0d want 25", o_sample2); end
    endtask

    task automatic test_overrun;
        int nv;
        i_states = 8'b00_00_00_10; i_signals = 64'h0000_0000_0000_0123;
        @(posedge clk); #1; clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        checks++; if (o_busy0 !== 1'b1) begin errors++; $display("FAIL busy_scan got %b want 1", o_busy0); end
        i_states = 8'hAA; i_signals = {4{16'sd1}};
        @(posedge clk); #1; clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_valid0) nv++;
        end
        checks++; if (nv !== 1 || o_sample0 !== 16'sd291) begin errors++; $display("FAIL overrun_single got %0d valids s=%0d want 1 291", nv, o_sample0); end
        checks++; if (o_overrun0 !== 1'b1 || o_overrun2 !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b/%b want 1", o_overrun0, o_overrun2); end
        i_clr_ovr = 1'b1;
        @(posedge clk); #1; i_clr_ovr = 1'b0;
        checks++; if (o_overrun0 !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", o_overrun0); end
        @(posedge clk); #1; clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        @(posedge clk); #1; clk_en = 1'b1; i_clr_ovr = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0; i_clr_ovr = 1'b0;
        checks++; if (o_overrun0 !== 1'b1) begin errors++; $display("FAIL overrun_set_wins got %b want 1", o_overrun0); end
        repeat (10) @(posedge clk);
        #1; i_clr_ovr = 1'b1;
        @(posedge clk); #1; i_clr_ovr = 1'b0;
        clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        repeat (4) @(posedge clk);
        #1; clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        checks++; if (o_valid0 !== 1'b1 || o_overrun0 !== 1'b1) begin errors++; $display("FAIL overrun_out_edge got v=%b ovr=%b want 1 1", o_valid0, o_overrun0); end
        nv = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (o_valid0 || o_busy0) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL overrun_out_norestart got %0d active cycles want 0", nv); end
    endtask

    task automatic test_reset_mid;
        int nv, lat, exp0, exp2, act;
        logic [63:0] sg;
        i_states = 8'hAA; i_signals = {4{16'sd500}};
        @(posedge clk); #1; clk_en = 1'b1;
        @(posedge clk); #1; clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        checks++; if (o_sample0 !== 16'sd0 || o_busy0 !== 1'b0 || o_overrun0 !== 1'b0 || o_active0 !== 3'd0) begin errors++; $display("FAIL reset_mid got s=%0d busy=%b ovr=%b a=%0d want 0", o_sample0, o_busy0, o_overrun0, o_active0); end
        @(posedge clk); #1; rst = 1'b0;
        nv = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (o_valid0) nv++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL reset_mid_novalid got %0d want 0", nv); end
        sg = {16'sd300, -16'sd40, 16'sd1234, 16'sd9};
        exp0 = model_mix(8'b10_00_10_10, sg, 0, act);
        exp2 = model_mix(8'b10_00_10_10, sg, 2, act);
        do_mix(8'b10_00_10_10, sg, lat);
        checks++; if (lat !== 5 || o_sample0 !== 16'(exp0) || o_sample2 !== 16'(exp2) || o_active0 !== 3'(act)) begin errors++; $display("FAIL reset_mid_fresh got lat=%0d s=%0d/%0d a=%0d want 5 %0d/%0d %0d", lat, o_sample0, o_sample2, o_active0, exp0, exp2, act); end
    endtask

    task automatic test_random;
        int lat, exp0, exp2, act;
        logic [7:0] st;
        logic [63:0] sg;
        for (int n = 0; n < 40; n++) begin
            st = 8'($urandom);
            if (n % 5 == 0) st = 8'hAA;
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: sg[16*k +: 16] = 16'h7FFF;
                    1: sg[16*k +: 16] = 16'h8000;
                    default: sg[16*k +: 16] = 16'($urandom);
                endcase
            end
            exp0 = model_mix(st, sg, 0, act);
            exp2 = model_mix(st, sg, 2, act);
            do_mix(st, sg, lat);
            checks++;
            if (lat !== 5 || o_sample0 !== 16'(exp0) || o_sample2 !== 16'(exp2)
                || o_active0 !== 3'(act) || o_active2 !== 3'(act)) begin
                errors++;
                $display("FAIL random[%0d] st=%h sg=%h got lat=%0d s=%0d/%0d a=%0d want 5 %0d/%0d %0d",
                         n, st, sg, lat, o_sample0, o_sample2, o_active0, exp0, exp2, act);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_snapshot;
        test_overrun;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
